// File: rtl/multi_sync_filter.sv
// multi_sync_filter
//
// Purpose:
//   Conditions NUM_CH asynchronous inputs for use in the clk domain. Each
//   channel is passed through a SYNC_STAGES-deep synchronizer, then a
//   stability filter that only accepts a new level after the synchronized
//   value has differed from the current output for FILTER_LEN consecutive
//   cycles. The clean level drives registered one-cycle rise/fall pulses and
//   a saturating per-channel edge counter.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_btn     in   asynchronous active-low reset
//   sig_in      in   [NUM_CH]            raw asynchronous inputs
//   cnt_clr     in   [NUM_CH]            synchronous per-channel counter clear
//   sig_out     out  [NUM_CH]            synchronized and filtered level
//   rise_pulse  out  [NUM_CH]            one-cycle pulse on sig_out 0->1
//   fall_pulse  out  [NUM_CH]            one-cycle pulse on sig_out 1->0
//   edge_cnt    out  [NUM_CH*CNT_WIDTH]  channel i count at [i*CNT_WIDTH +: CNT_WIDTH]
//   cnt_sat     out  [NUM_CH]            channel i count is at its maximum
//
// EDGE_MODE: 0 = count rising edges, 1 = falling, 2 = both.

module multi_sync_filter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int EDGE_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst_btn,
    input  logic [NUM_CH-1:0]             sig_in,
    input  logic [NUM_CH-1:0]             cnt_clr,
    output logic [NUM_CH-1:0]             sig_out,
    output logic [NUM_CH-1:0]             rise_pulse,
    output logic [NUM_CH-1:0]             fall_pulse,
    output logic [NUM_CH*CNT_WIDTH-1:0]   edge_cnt,
    output logic [NUM_CH-1:0]             cnt_sat
);

    localparam int                    STAB_W    = $clog2(FILTER_LEN) + 1;
    localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(FILTER_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;
        logic                   s;
        logic [STAB_W-1:0]      stab_q, stab_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
        logic                   qual;

        // Shift chain: stage 0 samples the pin, only the last stage is used.
        assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in[g]};
        assign s      = sync_q[SYNC_STAGES-1];

        always_comb begin
            stab_d  = stab_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s == level_q) begin
                // Agreement (or a return before acceptance) drops any pending change.
                stab_d = '0;
            end else if (stab_q == STAB_LAST) begin
                level_d = s;
                stab_d  = '0;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end

        always_comb begin
            qual = 1'b0;
            if (EDGE_MODE == 0)      qual = rise_d;
            else if (EDGE_MODE == 1) qual = fall_d;
            else                     qual = rise_d | fall_d;
        end

        // A clear coinciding with a qualifying edge keeps that edge (count = 1).
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr[g]) begin
                cnt_d = qual ? CNT_ONE : '0;
            end else if (qual && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_btn) begin
            if (!rst_btn) begin
                sync_q  <= '0;
                stab_q  <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync_q  <= sync_d;
                stab_q  <= stab_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                cnt_q   <= cnt_d;
            end
        end

        assign sig_out[g]                           = level_q;
        assign rise_pulse[g]                        = rise_q;
        assign fall_pulse[g]                        = fall_q;
        assign edge_cnt[g*CNT_WIDTH +: CNT_WIDTH]   = cnt_q;
        assign cnt_sat[g]                           = (cnt_q == CNT_MAX);
    end

endmodule

// File: tb/tb_multi_sync_filter.sv
// Testbench for multi_sync_filter: a default instance (dut) and an instance
// with EDGE_MODE=2, FILTER_LEN=1, SYNC_STAGES=3 (dut2). A window-based
// reference model tracks both every cycle; tables and hand sequences add
// fixed expectations for the corner cases.

module tb_multi_sync_filter;

    logic        clk;
    logic        rst_btn;
    logic [3:0]  sig_in, cnt_clr, sig_out, rise_pulse, fall_pulse, cnt_sat;
    logic [31:0] edge_cnt;
    logic [3:0]  sig_in2, cnt_clr2, sig_out2, rise_pulse2, fall_pulse2, cnt_sat2;
    logic [31:0] edge_cnt2;

    int n_pass  = 0;
    int n_total = 0;

    multi_sync_filter dut (
        .clk(clk), .rst_btn(rst_btn), .sig_in(sig_in), .cnt_clr(cnt_clr),
        .sig_out(sig_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_cnt(edge_cnt), .cnt_sat(cnt_sat)
    );

    multi_sync_filter #(.SYNC_STAGES(3), .FILTER_LEN(1), .EDGE_MODE(2)) dut2 (
        .clk(clk), .rst_btn(rst_btn), .sig_in(sig_in2), .cnt_clr(cnt_clr2),
        .sig_out(sig_out2), .rise_pulse(rise_pulse2), .fall_pulse(fall_pulse2),
        .edge_cnt(edge_cnt2), .cnt_sat(cnt_sat2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Level flips when the last FL synchronized samples (sig_in captured SS
    // edges earlier and before) all differ from the current level.
    int          m_ss[2]   = '{2, 3};
    int          m_fl[2]   = '{4, 1};
    int          m_mode[2] = '{0, 2};
    logic [3:0]  m_hist[2][16];
    logic [3:0]  m_lvl[2];
    logic [3:0]  m_rise[2];
    logic [3:0]  m_fall[2];
    logic [7:0]  m_cnt[2][4];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) m_hist[m][k] = 4'h0;
            m_lvl[m]  = 4'h0;
            m_rise[m] = 4'h0;
            m_fall[m] = 4'h0;
            for (int c = 0; c < 4; c++) m_cnt[m][c] = 8'h00;
        end
    endtask

    task automatic model_step(input int m, input logic [3:0] din, input logic [3:0] clr);
        logic accept;
        logic qual;
        for (int k = 15; k > 0; k--) m_hist[m][k] = m_hist[m][k-1];
        m_hist[m][0] = din;
        for (int c = 0; c < 4; c++) begin
            accept = 1'b1;
            for (int k = m_ss[m]; k < m_ss[m] + m_fl[m]; k++)
                if (m_hist[m][k][c] == m_lvl[m][c]) accept = 1'b0;
            m_rise[m][c] = 1'b0;
            m_fall[m][c] = 1'b0;
            if (accept) begin
                m_lvl[m][c] = ~m_lvl[m][c];
                if (m_lvl[m][c]) m_rise[m][c] = 1'b1;
                else             m_fall[m][c] = 1'b1;
            end
            if (m_mode[m] == 0)      qual = m_rise[m][c];
            else if (m_mode[m] == 1) qual = m_fall[m][c];
            else                     qual = m_rise[m][c] | m_fall[m][c];
            if (clr[c])                          m_cnt[m][c] = qual ? 8'd1 : 8'd0;
            else if (qual && m_cnt[m][c] != 8'hFF) m_cnt[m][c] = m_cnt[m][c] + 8'd1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_models();
        logic [31:0] ec0, ec1;
        logic [3:0]  es0, es1;
        for (int c = 0; c < 4; c++) begin
            ec0[c*8 +: 8] = m_cnt[0][c];
            ec1[c*8 +: 8] = m_cnt[1][c];
            es0[c]        = (m_cnt[0][c] == 8'hFF);
            es1[c]        = (m_cnt[1][c] == 8'hFF);
        end
        chk("m0_out",  sig_out,    m_lvl[0]);
        chk("m0_rise", rise_pulse, m_rise[0]);
        chk("m0_fall", fall_pulse, m_fall[0]);
        chk("m0_cnt",  edge_cnt,   ec0);
        chk("m0_sat",  cnt_sat,    es0);
        chk("m1_out",  sig_out2,    m_lvl[1]);
        chk("m1_rise", rise_pulse2, m_rise[1]);
        chk("m1_fall", fall_pulse2, m_fall[1]);
        chk("m1_cnt",  edge_cnt2,   ec1);
        chk("m1_sat",  cnt_sat2,    es1);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_btn) begin
            model_step(0, sig_in, cnt_clr);
            model_step(1, sig_in2, cnt_clr2);
        end
        @(negedge clk);
        check_models();
    endtask

    task automatic do_reset();
        rst_btn = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_btn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  din;
        logic [3:0]  clr;
        logic [3:0]  e_out;
        logic [3:0]  e_rise;
        logic [3:0]  e_fall;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [3:0] din, input logic [3:0] e_out, input logic [3:0] e_rise,
                           input logic [3:0] e_fall, input logic [31:0] e_cnt);
        vec_t v;
        v.din = din; v.clr = 4'h0; v.e_out = e_out; v.e_rise = e_rise;
        v.e_fall = e_fall; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            sig_in  = tbl[i].din;
            cnt_clr = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_out", i),  sig_out,    tbl[i].e_out);
            chk($sformatf("vec%0d_rise", i), rise_pulse, tbl[i].e_rise);
            chk($sformatf("vec%0d_fall", i), fall_pulse, tbl[i].e_fall);
            chk($sformatf("vec%0d_cnt", i),  edge_cnt,   tbl[i].e_cnt);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nr, nf;

        // Table 0..7: release with all inputs high, accepted on edge 6.
        for (int i = 0; i < 8; i++)
            add_vec(4'hF, (i >= 5) ? 4'hF : 4'h0, (i == 5) ? 4'hF : 4'h0, 4'h0,
                    (i >= 5) ? 32'h01010101 : 32'h0);
        // Table 8..15: 3-cycle glitch on ch0 is rejected.
        for (int i = 0; i < 8; i++)
            add_vec((i < 3) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
        // Table 16..27: 4-cycle pulse on ch0 is accepted, then drops back.
        for (int j = 0; j < 12; j++)
            add_vec((j < 4) ? 4'h1 : 4'h0, (j >= 5 && j <= 8) ? 4'h1 : 4'h0,
                    (j == 5) ? 4'h1 : 4'h0, (j == 9) ? 4'h1 : 4'h0,
                    (j >= 5) ? 32'h1 : 32'h0);

        rst_btn  = 1'b0;
        sig_in   = 4'hF;
        cnt_clr  = 4'h0;
        sig_in2  = 4'h0;
        cnt_clr2 = 4'h0;
        model_reset();
        repeat (3) tick();
        chk("rst_out",  sig_out,    4'h0);
        chk("rst_rise", rise_pulse, 4'h0);
        chk("rst_cnt",  edge_cnt,   32'h0);
        chk("rst_sat",  cnt_sat,    4'h0);
        rst_btn = 1'b1;
        run_vectors(0, 7);

        // Glitch rejection from a fresh reset with inputs low.
        sig_in = 4'h0;
        do_reset();
        run_vectors(8, 27);

        // Saturation on ch1.
        sig_in = 4'h0;
        for (int r = 0; r < 260; r++) begin
            sig_in[1] = 1'b1;
            repeat (8) tick();
            sig_in[1] = 1'b0;
            repeat (8) tick();
        end
        repeat (6) tick();
        chk("sat_cnt",  edge_cnt[15:8], 8'd255);
        chk("sat_flag", cnt_sat[1],     1'b1);
        cnt_clr[1] = 1'b1;
        tick();
        cnt_clr[1] = 1'b0;
        chk("clr_cnt",  edge_cnt[15:8], 8'd0);
        chk("clr_sat",  cnt_sat[1],     1'b0);

        // Clear colliding with a rising edge on ch2.
        repeat (2) begin
            sig_in[2] = 1'b1;
            repeat (6) tick();
            sig_in[2] = 1'b0;
            repeat (6) tick();
        end
        chk("pre_coll_cnt", edge_cnt[23:16], 8'd2);
        sig_in[2] = 1'b1;
        repeat (5) tick();
        cnt_clr[2] = 1'b1;
        tick();
        cnt_clr[2] = 1'b0;
        chk("coll_rise", rise_pulse[2],   1'b1);
        chk("coll_cnt",  edge_cnt[23:16], 8'd1);

        // Asynchronous reset while ch3 is mid-filter.
        sig_in[3] = 1'b1;
        repeat (4) tick();
        #2;
        rst_btn = 1'b0;
        model_reset();
        #1;
        chk("ar_out",  sig_out,    4'h0);
        chk("ar_rise", rise_pulse, 4'h0);
        chk("ar_fall", fall_pulse, 4'h0);
        chk("ar_cnt",  edge_cnt,   32'h0);
        chk("ar_sat",  cnt_sat,    4'h0);
        repeat (2) tick();
        rst_btn = 1'b1;
        repeat (5) tick();
        chk("ar_e5_out", sig_out[3], 1'b0);
        tick();
        chk("ar_e6_out",  sig_out[3],    1'b1);
        chk("ar_e6_rise", rise_pulse[3], 1'b1);

        // dut2: both-edge counting, no filtering, 3-stage synchronizer.
        nr = 0;
        nf = 0;
        for (int t = 0; t < 10; t++) begin
            sig_in2[0] = ~sig_in2[0];
            for (int c = 0; c < 5; c++) begin
                tick();
                nr += int'(rise_pulse2[0]);
                nf += int'(fall_pulse2[0]);
                if (t == 0 && c == 2) chk("d2_lat_e3", sig_out2[0], 1'b0);
                if (t == 0 && c == 3) chk("d2_lat_e4", sig_out2[0], 1'b1);
            end
        end
        repeat (5) tick();
        chk("d2_cnt0",  edge_cnt2[7:0],  8'd10);
        chk("d2_rises", nr,              5);
        chk("d2_falls", nf,              5);
        chk("d2_ch1_out", sig_out2[1],   1'b0);
        chk("d2_ch1_cnt", edge_cnt2[15:8], 8'd0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) sig_in[c]  = ~sig_in[c];
                if ($urandom_range(0, 3) == 0) sig_in2[c] = ~sig_in2[c];
                cnt_clr[c]  = ($urandom_range(0, 31) == 0);
                cnt_clr2[c] = ($urandom_range(0, 31) == 0);
            end
            tick();
        end
        cnt_clr  = 4'h0;
        cnt_clr2 = 4'h0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
